// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter/sequencer sharing one register file between NUM_REQ requesters
// Optional request locking is compiled in with `define REGFILE_ARBITER_LOCK_EN.
module regfile_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int SEL_WIDTH      = 3,
  parameter int NUM_REQ        = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]      req_wsel,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]      req_rsel1,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]      req_rsel2,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0] req_wdata,
`ifdef REGFILE_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]                req_lock,
`endif
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [DATA_BUS_WIDTH-1:0]         resp_rdata1,
  output logic [DATA_BUS_WIDTH-1:0]         resp_rdata2,
  output logic                              rf_we,
  output logic [SEL_WIDTH-1:0]              rf_in_sel,
  output logic [SEL_WIDTH-1:0]              rf_1_out_sel,
  output logic [SEL_WIDTH-1:0]              rf_2_out_sel,
  output logic [DATA_BUS_WIDTH-1:0]         rf_data_in,
  input  logic [DATA_BUS_WIDTH-1:0]         rf_1_out,
  input  logic [DATA_BUS_WIDTH-1:0]         rf_2_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          last_grant, grant_idx, win_idx, cand;
  logic                      win_found;
  logic                      win_write;
  logic [SEL_WIDTH-1:0]      win_wsel, win_rsel1, win_rsel2;
  logic [DATA_BUS_WIDTH-1:0] win_wdata;
  logic                      cap_write;
  logic [SEL_WIDTH-1:0]      cap_wsel, cap_rsel1, cap_rsel2;
  logic [DATA_BUS_WIDTH-1:0] cap_wdata;
`ifdef REGFILE_ARBITER_LOCK_EN
  logic                      locked;
`endif

  // Rotating search starting one past the last grant
  always_comb begin
    cand      = last_grant;
    win_found = 1'b0;
    win_idx   = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef REGFILE_ARBITER_LOCK_EN
    if (locked) begin
      win_found = req_valid[grant_idx];
      win_idx   = grant_idx;
    end
`endif
  end

  always_comb begin
    win_write = 1'b0;
    win_wsel  = '0;
    win_rsel1 = '0;
    win_rsel2 = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_write = req_write[i];
        win_wsel  = req_wsel[i*SEL_WIDTH +: SEL_WIDTH];
        win_rsel1 = req_rsel1[i*SEL_WIDTH +: SEL_WIDTH];
        win_rsel2 = req_rsel2[i*SEL_WIDTH +: SEL_WIDTH];
        win_wdata = req_wdata[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    resp_valid = '0;
    rf_we      = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready  = NUM_REQ'(1) << win_idx;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        rf_we      = cap_write;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = NUM_REQ'(1) << grant_idx;
        if (resp_ready[grant_idx]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Selects and write data come straight from the captured fields, so they hold outside ACCESS
  assign rf_in_sel    = cap_wsel;
  assign rf_1_out_sel = cap_rsel1;
  assign rf_2_out_sel = cap_rsel2;
  assign rf_data_in   = cap_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant_idx   <= '0;
      cap_write   <= 1'b0;
      cap_wsel    <= '0;
      cap_rsel1   <= '0;
      cap_rsel2   <= '0;
      cap_wdata   <= '0;
      resp_rdata1 <= '0;
      resp_rdata2 <= '0;
`ifdef REGFILE_ARBITER_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            cap_write <= win_write;
            cap_wsel  <= win_wsel;
            cap_rsel1 <= win_rsel1;
            cap_rsel2 <= win_rsel2;
            cap_wdata <= win_wdata;
`ifdef REGFILE_ARBITER_LOCK_EN
            if (!locked) last_grant <= win_idx;
`else
            last_grant <= win_idx;
`endif
          end
        end
        // The write lands on this same edge, so the reads see the old contents
        ACCESS: begin
          resp_rdata1 <= rf_1_out;
          resp_rdata2 <= rf_2_out;
        end
        RESP: begin
`ifdef REGFILE_ARBITER_LOCK_EN
          if (resp_ready[grant_idx]) locked <= req_lock[grant_idx];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a behavioural register file
module tb_regfile_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_write = '0;
  logic [5:0] req_wsel = '0, req_rsel1 = '0, req_rsel2 = '0;
  logic [15:0] req_wdata = '0;
`ifdef REGFILE_ARBITER_LOCK_EN
  logic [1:0] req_lock = '0;
`endif
  logic [1:0] resp_valid, resp_ready = '0;
  logic [7:0] resp_rdata1, resp_rdata2, rf_data_in, rf_1_out, rf_2_out;
  logic       rf_we;
  logic [2:0] rf_in_sel, rf_1_out_sel, rf_2_out_sel;

  typedef struct {
    int         r;
    logic [7:0] d1;
    logic [7:0] d2;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  logic [7:0] rf_mem [8];
  logic [7:0] shadow [8];
  int         total = 0, bad = 0, we_cycles = 0, multi_ready = 0;

  always #5 clock = ~clock;

  regfile_arbiter #(.DATA_BUS_WIDTH(8), .SEL_WIDTH(3), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wsel(req_wsel), .req_rsel1(req_rsel1), .req_rsel2(req_rsel2), .req_wdata(req_wdata),
`ifdef REGFILE_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2),
    .rf_we(rf_we), .rf_in_sel(rf_in_sel), .rf_1_out_sel(rf_1_out_sel), .rf_2_out_sel(rf_2_out_sel),
    .rf_data_in(rf_data_in), .rf_1_out(rf_1_out), .rf_2_out(rf_2_out)
  );

  always @(posedge clock) if (rf_we) rf_mem[rf_in_sel] <= rf_data_in;
  assign rf_1_out = rf_mem[rf_1_out_sel];
  assign rf_2_out = rf_mem[rf_2_out_sel];

  always @(negedge clock) begin
    if (rf_we) we_cycles++;
    if ($countones(req_ready) > 1) multi_ready++;
    if ((req_valid & req_ready) != 2'b00) grant_log.push_back(req_ready[1] ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input int r, input bit wr, input logic [2:0] ws, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] wd, input int stall);
    exp_t e;
    int   n, we0, other;
    other = 1 - r;
    e.r = r; e.d1 = shadow[rs1]; e.d2 = shadow[rs2];
    sb.push_back(e);
    if (wr) shadow[ws] = wd;
    req_write[r] = wr; req_wsel[r*3 +: 3] = ws; req_rsel1[r*3 +: 3] = rs1;
    req_rsel2[r*3 +: 3] = rs2; req_wdata[r*8 +: 8] = wd; req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin @(posedge clock); #1; n++; end
    check("req_ready_grant", {31'b0, req_ready[r]}, 1);
    we0 = we_cycles;
    @(posedge clock); #1;
    req_valid[r] = 1'b0;
    check("access_rf_we", {31'b0, rf_we}, {31'b0, wr});
    check("access_rsel1", rf_1_out_sel, rs1);
    check("access_rsel2", rf_2_out_sel, rs2);
    if (wr) begin
      check("access_in_sel", rf_in_sel, ws);
      check("access_data_in", rf_data_in, wd);
    end
    @(posedge clock); #1;
    check("resp_valid_lat2", resp_valid, 32'(1 << r));
    e = sb.pop_front();
    check("resp_rdata1", resp_rdata1, e.d1);
    check("resp_rdata2", resp_rdata2, e.d2);
    if (stall > 0) begin
      req_valid[other] = 1'b1;
      resp_ready[other] = 1'b1;
      repeat (stall) begin
        @(posedge clock); #1;
        check("stall_resp_valid", resp_valid, 32'(1 << r));
        check("stall_rdata1", resp_rdata1, e.d1);
        check("stall_rdata2", resp_rdata2, e.d2);
        check("stall_req_ready", req_ready, 0);
      end
      req_valid[other] = 1'b0;
      resp_ready[other] = 1'b0;
    end
    resp_ready[r] = 1'b1;
    @(posedge clock); #1;
    resp_ready[r] = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("we_pulse_count", we_cycles - we0, {31'b0, wr});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin rf_mem[i] = 8'h00; shadow[i] = 8'h00; end

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rf_we", {31'b0, rf_we}, 0);
    check("rst_sels", {rf_in_sel, rf_1_out_sel, rf_2_out_sel, rf_data_in}, 0);
    check("rst_rdata", {resp_rdata1, resp_rdata2}, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // write then read-back of reg 3
    do_txn(0, 1'b1, 3'd3, 3'd3, 3'd0, 8'h5A, 0);
    do_txn(1, 1'b0, 3'd0, 3'd3, 3'd3, 8'h00, 0);

    // continuous contention: strict alternation
    req_write = 2'b00; req_rsel1 = {3'd2, 3'd1}; req_rsel2 = {3'd4, 3'd3};
    resp_ready = 2'b11;
    grant_log.delete();
    multi_ready = 0;
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < 6 && n < 100) begin @(posedge clock); #1; n++; end
    req_valid = 2'b00;
    repeat (4) @(posedge clock);
    #1;
    resp_ready = 2'b00;
    check("fair_grant_count", {31'b0, grant_log.size() >= 6}, 1);
    for (int i = 0; i < 6; i++) check("fair_order", grant_log[i], i % 2);
    check("fair_one_hot_ready", multi_ready, 0);

    // back-pressure on the response
    do_txn(0, 1'b0, 3'd0, 3'd3, 3'd0, 8'h00, 5);

    // reset while in ACCESS
    req_write[1] = 1'b1; req_wsel[5:3] = 3'd5; req_wdata[15:8] = 8'h77;
    req_rsel1[5:3] = 3'd5; req_rsel2[5:3] = 3'd3; req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    check("midrst_in_access", {31'b0, rf_we}, 1);
    reset = 1'b0;
    req_valid = 2'b00;
    #1;
    check("midrst_rf_we", {31'b0, rf_we}, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_sels", {rf_in_sel, rf_1_out_sel, rf_2_out_sel, rf_data_in}, 0);
    check("midrst_rdata", {resp_rdata1, resp_rdata2}, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    req_write = 2'b00;
    req_valid = 2'b11;
    #1;
    check("postrst_first_grant", req_ready, 32'b01);
    req_valid = 2'b00;
    #1;
    do_txn(0, 1'b0, 3'd0, 3'd3, 3'd5, 8'h00, 0);

`ifdef REGFILE_ARBITER_LOCK_EN
    req_write = 2'b00;
    resp_ready = 2'b11;
    req_lock = 2'b10;
    grant_log.delete();
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin
      @(posedge clock); #1; n++;
      if (grant_log.size() >= 3) req_lock = 2'b00;
    end
    req_valid = 2'b00;
    repeat (4) @(posedge clock);
    #1;
    resp_ready = 2'b00;
    check("lock_grant_count", {31'b0, grant_log.size() >= 4}, 1);
    for (int i = 0; i < 4; i++) check("lock_order", grant_log[i], (i < 3) ? 1 : 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
